prog_launcher: RTL and testbench
================================

// Module: prog_launcher
// PURPOSE
//  Host-side driver for the processor's Start/Ack handshake: the initiator end of the interface TopLevel answers.
//  On Req it runs NumRuns programs back-to-back. Each run pulses Start, waits for the DUT to drop Ack, then counts cycles until Ack rises.
//  Reports per-run cycle count and flags a hung DUT via timeout. Sits in the bench/FPGA wrapper beside TopLevel.
// PARAMETERS
//  START_LEN  2        cycles Start is held high per run (>=1)
//  CW         16       cycle-counter width
//  MAX_CYC    16'hFFF0 timeout: RUN cycles before abort (< 2**CW)
//  ARM_TO     8        cycles allowed for Ack to fall after Start drops
// PORTS
//  Clk        in   1   clock, posedge
//  Reset_n    in   1   async reset, active low
//  Req        in   1   launch request, sampled only in IDLE
//  NumRuns    in   2   programs to run per request (0..3)
//  Ack        in   1   DUT done flag (TopLevel Ack)
//  Start      out  1   to DUT Start, registered
//  Busy       out  1   high from cycle after Req accept until Done
//  RunIdx     out  2   index of current/last run, 0-based
//  CycleCt    out  CW  cycle count of last completed run
//  CycleVld   out  1   1-cycle pulse: CycleCt/RunIdx valid
//  Done       out  1   1-cycle pulse: sequence finished or aborted
//  TimedOut   out  1   sticky error; cleared on next Req accept
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state IDLE; all outputs 0, Start drops immediately; counters 0.
//  - FSM: IDLE -> START -> ARM -> RUN -> REPORT -> (START | FIN) -> IDLE.
//  - IDLE: Req=1 at edge -> Busy=1, TimedOut=0, RunIdx=0.
//    If NumRuns=0, go to FIN (Done next cycle, no Start). Otherwise go to START.
//  - START: Start=1 for exactly START_LEN cycles. Ack is ignored during START.
//  - ARM: Start=0; wait until Ack sampled 0. If Ack stays 1 for ARM_TO cycles -> TimedOut=1 -> FIN.
//  - RUN: count cleared on entry.
//    Each edge with Ack=0: count+1. First edge with Ack=1: CycleCt<=count -> REPORT.
//    CycleCt = number of RUN cycles with Ack low.
//    If count reaches MAX_CYC before Ack -> TimedOut=1, CycleCt<=MAX_CYC, CycleVld pulses -> FIN (remaining runs skipped).
//  - REPORT: CycleVld=1 for one cycle.
//    If RunIdx==NumRuns-1 -> FIN; else RunIdx+1 -> START.
//  - NumRuns is latched on Req accept; later changes are ignored.
//  - FIN: Done=1 for one cycle, Busy<=0 -> IDLE.
//  - Req while Busy: ignored, no queueing.
//  - Req held high across FIN: relaunch on first IDLE cycle.
//  - Counter saturates at 2**CW-1; it never wraps.
//  - Reset mid-run: abandons the sequence, and CycleCt reads 0 afterwards.
// CONFIGURATION
//  LAUNCH_STATS_EN: when defined, adds outputs TotCyc[CW+2-1:0] and MaxCyc[CW-1:0].
//    Both are cleared on Req accept and updated on each CycleVld (sum / running max).
//    When undefined, the ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package definitions: typedef enum logic[2:0] launch_st_t {L_IDLE, L_START, L_ARM, L_RUN, L_REPORT, L_FIN}.
//  - Package definitions also holds localparam default for MAX_CYC.
//  - One sub-module: sat_counter #(W) — clear, enable, saturate-at-max, AtLimit output.
//    Used for both the RUN count and the START/ARM timer.
// TESTING
//  1 NumRuns=1, START_LEN=2; Ack falls 1 cycle after Start drops and rises 10 cycles later.
//    -> Start high exactly 2 cycles; CycleVld with CycleCt=10, RunIdx=0; Done next cycle.
//  2 NumRuns=3; DUT model halts after 5, 7, 9 cycles.
//    -> three CycleVld pulses (5/0, 7/1, 9/2), three Start pulses, a single Done, TimedOut=0.
//  3 Ack never rises, MAX_CYC=20 -> CycleVld with CycleCt=20; TimedOut=1 and Done; remaining runs skipped.
//  4 Ack stuck high after Start, ARM_TO=8 -> 8 ARM cycles, then TimedOut=1, Done, CycleVld never pulses.
//  5 Reset_n low mid-RUN, then Req again.
//    -> Start/Busy drop asynchronously, CycleCt=0, clean fresh sequence; NumRuns=0 Req -> Done 1 cycle after accept, Start never high.
//  6 With LAUNCH_STATS_EN, run 2 gives 5 and 9 -> TotCyc=14, MaxCyc=9; Req while Busy is ignored.

Source files
------------

// File: rtl/prog_launcher_pkg.sv
// prog_launcher shared types: launcher FSM state encoding
// and the default RUN-phase timeout.
package prog_launcher_pkg;

  typedef enum logic [2:0] {
    L_IDLE,
    L_START,
    L_ARM,
    L_RUN,
    L_REPORT,
    L_FIN
  } launch_st_t;

  localparam logic [15:0] MAX_CYC_DEF = 16'hFFF0;

endpackage

// File: rtl/prog_launcher_sat_counter.sv
// sat_counter: up-counter with clear, enable, saturation at all-ones.
// Ports: Clk, Reset_n, Clr, En, Limit -> Count, AtLimit (Count >= Limit).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Clr,
  input  logic         En,
  input  logic [W-1:0] Limit,
  output logic [W-1:0] Count,
  output logic         AtLimit
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (Clr) begin
      cnt <= '0;
    end else if (En && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Count   = cnt;
  assign AtLimit = (cnt >= Limit);

endmodule

// File: rtl/prog_launcher.sv
// prog_launcher: initiator end of the Start/Ack handshake; runs NumRuns
// programs per Req, times each run, flags hung DUT via TimedOut.
// Ports: Clk, Reset_n, Req, NumRuns, Ack -> Start, Busy, RunIdx,
//   CycleCt, CycleVld, Done, TimedOut.
// Option LAUNCH_STATS_EN adds TotCyc (sum) and MaxCyc (running max).
module prog_launcher
  import prog_launcher_pkg::*;
#(
  parameter int          START_LEN = 2,
  parameter int          CW        = 16,
  parameter int unsigned MAX_CYC   = 32'(MAX_CYC_DEF),
  parameter int          ARM_TO    = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Req,
  input  logic [1:0]    NumRuns,
  input  logic          Ack,
  output logic          Start,
  output logic          Busy,
  output logic [1:0]    RunIdx,
  output logic [CW-1:0] CycleCt,
  output logic          CycleVld,
  output logic          Done,
`ifdef LAUNCH_STATS_EN
  output logic [CW+1:0] TotCyc,
  output logic [CW-1:0] MaxCyc,
`endif
  output logic          TimedOut
);

  localparam logic [CW-1:0] CycMax   = CW'(MAX_CYC);
  localparam logic [CW-1:0] LimStart = CW'(START_LEN - 1);
  localparam logic [CW-1:0] LimArm   = CW'(ARM_TO - 1);
  localparam logic [CW-1:0] LimRun   = CW'(MAX_CYC - 1);

  launch_st_t st, stNxt;

  logic          startQ, busyQ, vldQ, doneQ, toQ;
  logic [1:0]    idxQ, numQ;
  logic [CW-1:0] ctQ;

  logic          accept, armTo, runTo, runDone, idxInc;
  logic          cntClr, cntEn, cntAt;
  logic [CW-1:0] cntLim, cntVal, ctNew;

  // One counter serves as START/ARM timer and RUN cycle count;
  // it is cleared on every phase change.
  sat_counter #(
    .W (CW)
  ) uCnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clr     (cntClr),
    .En      (cntEn),
    .Limit   (cntLim),
    .Count   (cntVal),
    .AtLimit (cntAt)
  );

  always_comb begin
    stNxt   = st;
    accept  = 1'b0;
    armTo   = 1'b0;
    runTo   = 1'b0;
    runDone = 1'b0;
    idxInc  = 1'b0;
    cntClr  = 1'b0;
    cntEn   = 1'b0;
    cntLim  = '1;
    unique case (st)
      L_IDLE: begin
        cntClr = 1'b1;
        if (Req) begin
          accept = 1'b1;
          stNxt  = (NumRuns == 2'd0) ? L_FIN : L_START;
        end
      end
      L_START: begin
        cntLim = LimStart;
        if (cntAt) begin
          cntClr = 1'b1;
          stNxt  = L_ARM;
        end else begin
          cntEn = 1'b1;
        end
      end
      L_ARM: begin
        cntLim = LimArm;
        if (!Ack) begin
          cntClr = 1'b1;
          stNxt  = L_RUN;
        end else if (cntAt) begin
          armTo = 1'b1;
          stNxt = L_FIN;
        end else begin
          cntEn = 1'b1;
        end
      end
      L_RUN: begin
        cntLim = LimRun;
        if (Ack) begin
          runDone = 1'b1;
          stNxt   = L_REPORT;
        end else if (cntAt) begin
          // this low cycle is the MAX_CYC-th one
          runTo = 1'b1;
          stNxt = L_FIN;
        end else begin
          cntEn = 1'b1;
        end
      end
      L_REPORT: begin
        cntClr = 1'b1;
        if (idxQ == numQ - 2'd1) begin
          stNxt = L_FIN;
        end else begin
          idxInc = 1'b1;
          stNxt  = L_START;
        end
      end
      L_FIN: begin
        cntClr = 1'b1;
        stNxt  = L_IDLE;
      end
      default: begin
        stNxt = L_IDLE;
      end
    endcase
  end

  assign ctNew = runTo ? CycMax : cntVal;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st     <= L_IDLE;
      startQ <= 1'b0;
      busyQ  <= 1'b0;
      vldQ   <= 1'b0;
      doneQ  <= 1'b0;
      toQ    <= 1'b0;
      idxQ   <= 2'd0;
      numQ   <= 2'd0;
      ctQ    <= '0;
    end else begin
      st     <= stNxt;
      startQ <= (stNxt == L_START);
      doneQ  <= (stNxt == L_FIN);
      vldQ   <= runDone | runTo;
      if (accept) begin
        busyQ <= 1'b1;
        toQ   <= 1'b0;
        idxQ  <= 2'd0;
        numQ  <= NumRuns;
      end
      if (st == L_FIN) begin
        busyQ <= 1'b0;
      end
      if (armTo || runTo) begin
        toQ <= 1'b1;
      end
      if (idxInc) begin
        idxQ <= idxQ + 2'd1;
      end
      if (runDone || runTo) begin
        ctQ <= ctNew;
      end
    end
  end

`ifdef LAUNCH_STATS_EN
  logic [CW+1:0] totQ;
  logic [CW-1:0] maxQ;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      totQ <= '0;
      maxQ <= '0;
    end else if (accept) begin
      totQ <= '0;
      maxQ <= '0;
    end else if (runDone || runTo) begin
      totQ <= totQ + {2'b00, ctNew};
      if (ctNew > maxQ) begin
        maxQ <= ctNew;
      end
    end
  end

  assign TotCyc = totQ;
  assign MaxCyc = maxQ;
`endif

  assign Start    = startQ;
  assign Busy     = busyQ;
  assign RunIdx   = idxQ;
  assign CycleCt  = ctQ;
  assign CycleVld = vldQ;
  assign Done     = doneQ;
  assign TimedOut = toQ;

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher with a small Start/Ack responder.
// Instance uses START_LEN=2, MAX_CYC=20, ARM_TO=8.
module tb_prog_launcher;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req = 1'b0;
  logic [1:0]  NumRuns = 2'd0;
  logic        Ack = 1'b1;
  logic        Start, Busy, CycleVld, Done, TimedOut;
  logic [1:0]  RunIdx;
  logic [15:0] CycleCt;
`ifdef LAUNCH_STATS_EN
  logic [17:0] TotCyc;
  logic [15:0] MaxCyc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  prog_launcher #(
    .START_LEN (2),
    .CW        (16),
    .MAX_CYC   (20),
    .ARM_TO    (8)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Req      (Req),
    .NumRuns  (NumRuns),
    .Ack      (Ack),
    .Start    (Start),
    .Busy     (Busy),
    .RunIdx   (RunIdx),
    .CycleCt  (CycleCt),
    .CycleVld (CycleVld),
    .Done     (Done),
`ifdef LAUNCH_STATS_EN
    .TotCyc   (TotCyc),
    .MaxCyc   (MaxCyc),
`endif
    .TimedOut (TimedOut)
  );

  // event recorder, sampled on the falling edge
  logic        monClr = 1'b0;
  logic        prevStart = 1'b0;
  int          cyc = 0;
  int          startCyc = 0;
  int          startPulses = 0;
  int          armCyc = 0;
  int          vldCnt = 0;
  int          doneCnt = 0;
  int          vldCyc = 0;
  int          doneCyc = 0;
  logic [15:0] vldCt [8];
  logic [1:0]  vldIdx [8];

  always @(negedge Clk) begin
    prevStart <= Start;
    if (monClr) begin
      cyc         <= 0;
      startCyc    <= 0;
      startPulses <= 0;
      armCyc      <= 0;
      vldCnt      <= 0;
      doneCnt     <= 0;
      vldCyc      <= 0;
      doneCyc     <= 0;
    end else if (Reset_n) begin
      cyc <= cyc + 1;
      if (Start) startCyc <= startCyc + 1;
      if (Start && !prevStart) startPulses <= startPulses + 1;
      if (Busy && !Start && !Done && !CycleVld) armCyc <= armCyc + 1;
      if (CycleVld) begin
        if (vldCnt < 8) begin
          vldCt[vldCnt[2:0]]  <= CycleCt;
          vldIdx[vldCnt[2:0]] <= RunIdx;
        end
        vldCnt <= vldCnt + 1;
        vldCyc <= cyc;
      end
      if (Done) begin
        doneCnt <= doneCnt + 1;
        doneCyc <= cyc;
      end
    end
  end

  task automatic clear_mon();
    monClr = 1'b1;
    @(negedge Clk);
    #1 monClr = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  // Responder: after Start falls, drop Ack one cycle later. The first
  // low edge is spent in ARM, so Ack stays low lat+1 edges to give
  // lat RUN cycles with Ack low.
  task automatic dut_run(input int lat, input bit stuckLow);
    int n;
    n = 0;
    while (!Start && n < 100) begin
      @(posedge Clk); #1; n++;
    end
    checks++;
    if (!Start) begin
      errors++;
      $display("FAIL dut_start: Start=%0b, required 1 within 100 cycles", Start);
      return;
    end
    n = 0;
    while (Start && n < 100) begin
      @(posedge Clk); #1; n++;
    end
    @(posedge Clk);
    #1 Ack = 1'b0;
    if (!stuckLow) begin
      repeat (lat + 1) @(posedge Clk);
      #1 Ack = 1'b1;
    end
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!Done && n < lim) begin
      @(negedge Clk); n++;
    end
    checks++;
    if (!Done) begin
      errors++;
      $display("FAIL wait_done: Done=%0b, required 1 within %0d cycles", Done, lim);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] n);
    Req = 1'b1;
    NumRuns = n;
    @(posedge Clk);
    #1 Req = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({Start, Busy, RunIdx, CycleCt, CycleVld, Done, TimedOut} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %b, required all 0",
               {Start, Busy, RunIdx, CycleCt, CycleVld, Done, TimedOut});
    end
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({Start, Busy, Done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b, required 000", {Start, Busy, Done});
    end
  endtask

  task automatic test_single();
    clear_mon();
    launch(2'd1);
    checks++;
    if ({Busy, Start} !== 2'b11) begin
      errors++;
      $display("FAIL single_accept: Busy,Start=%b, required 11", {Busy, Start});
    end
    dut_run(10, 1'b0);
    wait_done(50);
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (startCyc !== 2) begin
      errors++;
      $display("FAIL single_start_len: got %0d cycles, required 2", startCyc);
    end
    checks++;
    if (vldCnt !== 1) begin
      errors++;
      $display("FAIL single_vld_cnt: got %0d, required 1", vldCnt);
    end
    checks++;
    if (vldCt[0] !== 16'd10 || vldIdx[0] !== 2'd0) begin
      errors++;
      $display("FAIL single_ct: got %0d/%0d, required 10/0", vldCt[0], vldIdx[0]);
    end
    checks++;
    if (doneCnt !== 1 || doneCyc !== vldCyc + 1) begin
      errors++;
      $display("FAIL single_done: got cnt %0d at %0d (vld %0d), required 1 at vld+1",
               doneCnt, doneCyc, vldCyc);
    end
    checks++;
    if ({Busy, TimedOut, CycleCt} !== {1'b0, 1'b0, 16'd10}) begin
      errors++;
      $display("FAIL single_final: Busy %0b TO %0b Ct %0d, required 0 0 10",
               Busy, TimedOut, CycleCt);
    end
  endtask

  task automatic test_multi();
    logic [15:0] expCt [3];
    expCt[0] = 16'd5;
    expCt[1] = 16'd7;
    expCt[2] = 16'd9;
    clear_mon();
    launch(2'd3);
    NumRuns = 2'd0;
    dut_run(5, 1'b0);
    Req = 1'b1;
    dut_run(7, 1'b0);
    Req = 1'b0;
    dut_run(9, 1'b0);
    wait_done(50);
    repeat (6) @(posedge Clk);
    #1;
    checks++;
    if (vldCnt !== 3) begin
      errors++;
      $display("FAIL multi_vld_cnt: got %0d, required 3", vldCnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vldCt[i] !== expCt[i] || vldIdx[i] !== 2'(i)) begin
        errors++;
        $display("FAIL multi_run%0d: got %0d/%0d, required %0d/%0d",
                 i, vldCt[i], vldIdx[i], expCt[i], i);
      end
    end
    checks++;
    if (startPulses !== 3 || startCyc !== 6) begin
      errors++;
      $display("FAIL multi_start: got %0d pulses %0d cycles, required 3 and 6",
               startPulses, startCyc);
    end
    checks++;
    if (doneCnt !== 1 || Busy !== 1'b0 || TimedOut !== 1'b0) begin
      errors++;
      $display("FAIL multi_done: Done cnt %0d Busy %0b TO %0b, required 1 0 0",
               doneCnt, Busy, TimedOut);
    end
  endtask

`ifdef LAUNCH_STATS_EN
  task automatic test_stats();
    clear_mon();
    launch(2'd2);
    checks++;
    if (TotCyc !== 18'd0 || MaxCyc !== 16'd0) begin
      errors++;
      $display("FAIL stats_clear: got %0d/%0d, required 0/0", TotCyc, MaxCyc);
    end
    dut_run(9, 1'b0);
    dut_run(5, 1'b0);
    wait_done(50);
    checks++;
    if (TotCyc !== 18'd14 || MaxCyc !== 16'd9) begin
      errors++;
      $display("FAIL stats_final: got %0d/%0d, required 14/9", TotCyc, MaxCyc);
    end
  endtask
`endif

  task automatic test_run_timeout();
    clear_mon();
    launch(2'd2);
    dut_run(0, 1'b1);
    wait_done(100);
    Ack = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    checks++;
    if (vldCnt !== 1 || vldCt[0] !== 16'd20 || vldIdx[0] !== 2'd0) begin
      errors++;
      $display("FAIL run_to_vld: got cnt %0d ct %0d idx %0d, required 1 20 0",
               vldCnt, vldCt[0], vldIdx[0]);
    end
    checks++;
    if (TimedOut !== 1'b1 || doneCnt !== 1 || doneCyc !== vldCyc) begin
      errors++;
      $display("FAIL run_to_done: TO %0b done %0d at %0d vld %0d, required 1 1 same",
               TimedOut, doneCnt, doneCyc, vldCyc);
    end
    checks++;
    if (startPulses !== 1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL run_to_skip: got %0d pulses Busy %0b, required 1 0",
               startPulses, Busy);
    end
  endtask

  task automatic test_arm_timeout();
    clear_mon();
    launch(2'd1);
    checks++;
    if (TimedOut !== 1'b0) begin
      errors++;
      $display("FAIL to_cleared: got %0b, required 0", TimedOut);
    end
    wait_done(100);
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (armCyc !== 8) begin
      errors++;
      $display("FAIL arm_cycles: got %0d, required 8", armCyc);
    end
    checks++;
    if (TimedOut !== 1'b1 || vldCnt !== 0 || doneCnt !== 1) begin
      errors++;
      $display("FAIL arm_to: TO %0b vld %0d done %0d, required 1 0 1",
               TimedOut, vldCnt, doneCnt);
    end
  endtask

  task automatic test_reset_midrun();
    clear_mon();
    launch(2'd2);
    dut_run(0, 1'b1);
    repeat (4) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({Busy, Start, CycleVld, Done, TimedOut, RunIdx} !== 7'd0 || CycleCt !== 16'd0) begin
      errors++;
      $display("FAIL midrun_reset: got %b ct %0d, required all 0",
               {Busy, Start, CycleVld, Done, TimedOut, RunIdx}, CycleCt);
    end
    #2 Reset_n = 1'b1;
    Ack = 1'b1;
    @(posedge Clk);
    #1;
    clear_mon();
    launch(2'd1);
    dut_run(4, 1'b0);
    wait_done(50);
    checks++;
    if (vldCnt !== 1 || vldCt[0] !== 16'd4 || CycleCt !== 16'd4 || startPulses !== 1) begin
      errors++;
      $display("FAIL fresh_run: vld %0d ct %0d/%0d pulses %0d, required 1 4 4 1",
               vldCnt, vldCt[0], CycleCt, startPulses);
    end
    launch(2'd2);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({Start, Busy} !== 2'b00) begin
      errors++;
      $display("FAIL start_async_drop: got %b, required 00", {Start, Busy});
    end
    #3 Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_zero_runs();
    clear_mon();
    launch(2'd0);
    @(negedge Clk);
    checks++;
    if ({Done, Busy, Start} !== 3'b110) begin
      errors++;
      $display("FAIL zero_done: Done,Busy,Start=%b, required 110", {Done, Busy, Start});
    end
    @(negedge Clk);
    checks++;
    if ({Done, Busy} !== 2'b00) begin
      errors++;
      $display("FAIL zero_idle: Done,Busy=%b, required 00", {Done, Busy});
    end
    @(posedge Clk);
    #1;
    checks++;
    if (startPulses !== 0 || doneCnt !== 1) begin
      errors++;
      $display("FAIL zero_counts: pulses %0d done %0d, required 0 1",
               startPulses, doneCnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    Req = 1'b1;
    NumRuns = 2'd0;
    repeat (6) @(posedge Clk);
    #1 Req = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    checks++;
    if (doneCnt !== 3 || startPulses !== 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: done %0d pulses %0d Busy %0b, required 3 0 0",
               doneCnt, startPulses, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
`ifdef LAUNCH_STATS_EN
    test_stats();
`endif
    test_run_timeout();
    test_arm_timeout();
    test_reset_midrun();
    test_zero_runs();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
